imdct_frame_reader: RTL and testbench

- Reader end of the shared dual-port output BRAM that the IMDCT stage writes one reconstructed frame into.
- On a start spike it fetches FRAME_LEN 32-bit words from port B, starting at a word-aligned byte address. It extracts the 16-bit PCM sample from bits [15:0] of each word.
- Samples stream out through a valid/ready interface, buffered in a small credit-controlled FIFO, toward the audio output path.
- It raises a sticky interrupt when the last sample of the frame has been accepted downstream.

---
 rtl/imdct_frame_reader.sv | 187 ++++++++++++++++++
 tb/tb_imdct_frame_reader.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imdct_frame_reader.sv
// imdct_frame_reader
//
// Reader side of the dual-port BRAM that the IMDCT stage fills with one
// reconstructed frame. A start spike fetches FRAME_LEN 32-bit words from
// port B, keeps the low 16 bits of each word as a signed PCM sample, and
// streams the samples out through a small FIFO with a valid/ready handshake.
// Reads are issued only while the FIFO has room for every outstanding read,
// so the FIFO can never overflow. A sticky interrupt flags frame completion.
//
// Ports:
//   clk_in, rst        system clock, synchronous active-high reset
//   start, frame_base  one-cycle start spike, byte address of sample 0
//   intr, intr_clr     sticky frame-complete interrupt and its clear
//   busy               high from start acceptance until the last handshake
//   bram_*             BRAM port B (read only; bram_web tied to 0)
//   sample_o/_valid/_ready/_last  output sample stream
module imdct_frame_reader #(
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] frame_base,
    output logic        intr,
    input  logic        intr_clr,
    output logic        busy,
    output logic [31:0] bram_addrb,
    output logic        bram_enb,
    output logic [3:0]  bram_web,
    input  logic [31:0] bram_doutb,
    output logic [15:0] sample_o,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        sample_last
);

    localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    // Holds fifo_count + issue-in-progress + every tagged read.
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } state_e;

    state_e             state;
    logic [31:0]        base_addr;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   out_idx;
    logic [RD_LAT-1:0]  rd_tag;

    logic [15:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic [OCC_W-1:0]   occ;
    logic               push;
    logic               pop;
    logic               last_hs;
    logic               can_issue;
    logic [31:0]        start_addr;
    logic               unused_bits;

    assign bram_web     = 4'b0000;
    assign start_addr   = {frame_base[31:2], 2'b00};
    assign unused_bits  = ^{bram_doutb[31:16], frame_base[1:0]};

    assign sample_valid = (fifo_count != '0);
    assign sample_o     = fifo_mem[rd_ptr];
    assign sample_last  = sample_valid && (out_idx == LAST_IDX);

    // The oldest tag marks the cycle in which bram_doutb carries read data.
    assign push    = rd_tag[RD_LAT-1];
    assign pop     = sample_valid && sample_ready;
    assign last_hs = pop && (out_idx == LAST_IDX);

    // Occupancy counts the read currently on the port (bram_enb) as in flight.
    always_comb begin
        occ = OCC_W'(fifo_count) + OCC_W'(bram_enb);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            occ = occ + OCC_W'(rd_tag[i]);
        end
    end

    // A pop on this edge frees one slot before the new read can land.
    assign can_issue = (state == StFetch) &&
                       ((occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH));

    // Control FSM with registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= StIdle;
            base_addr  <= '0;
            rd_idx     <= '0;
            out_idx    <= '0;
            busy       <= 1'b0;
            intr       <= 1'b0;
            bram_enb   <= 1'b0;
            bram_addrb <= '0;
        end else begin
            bram_enb <= 1'b0;

            if (pop) begin
                out_idx <= out_idx + IDX_W'(1);
            end

            // Completion wins over a simultaneous clear.
            if (last_hs) begin
                intr <= 1'b1;
            end else if (intr_clr) begin
                intr <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        // Sample 0 is issued on the acceptance edge itself.
                        base_addr  <= start_addr;
                        bram_addrb <= start_addr;
                        bram_enb   <= 1'b1;
                        rd_idx     <= IDX_W'(1);
                        out_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= (FRAME_LEN == 1) ? StDrain : StFetch;
                    end
                end
                StFetch: begin
                    if (can_issue) begin
                        bram_enb   <= 1'b1;
                        bram_addrb <= base_addr + (32'(rd_idx) << 2);
                        rd_idx     <= rd_idx + IDX_W'(1);
                        if (rd_idx == LAST_IDX) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (last_hs) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Read-return tags and output FIFO.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rd_tag     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            rd_tag[0] <= bram_enb;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rd_tag[i] <= rd_tag[i-1];
            end

            if (push) begin
                fifo_mem[wr_ptr] <= bram_doutb[15:0];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imdct_frame_reader.sv
// Directed bench for imdct_frame_reader. Two instances share the clock and
// reset: dut1 with RD_LAT=1 and dut2 with RD_LAT=2. Each BRAM model returns
// {16'hDEAD, ((addr-0x100)>>2)[15:0]} so a frame at 0x100 yields 0x0000..0x00FF,
// and drives junk when no read was issued. Expected addresses and samples are
// queued when a frame is started and popped as reads and handshakes occur.
module tb_imdct_frame_reader;

    localparam int unsigned FRAME_LEN  = 256;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk_in;
    logic        rst;
    logic        start1;
    logic        start2;
    logic [31:0] frame_base;
    logic        intr_clr;
    logic        sample_ready;

    logic        intr1, busy1, enb1, valid1, last1;
    logic [31:0] addr1, dout1;
    logic [3:0]  web1;
    logic [15:0] smp1;

    logic        intr2, busy2, enb2, valid2, last2;
    logic [31:0] addr2, dout2, stage2;
    logic [3:0]  web2;
    logic [15:0] smp2;

    imdct_frame_reader #(
        .FRAME_LEN  (FRAME_LEN),
        .RD_LAT     (1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut1 (
        .clk_in       (clk_in),
        .rst          (rst),
        .start        (start1),
        .frame_base   (frame_base),
        .intr         (intr1),
        .intr_clr     (intr_clr),
        .busy         (busy1),
        .bram_addrb   (addr1),
        .bram_enb     (enb1),
        .bram_web     (web1),
        .bram_doutb   (dout1),
        .sample_o     (smp1),
        .sample_valid (valid1),
        .sample_ready (sample_ready),
        .sample_last  (last1)
    );

    imdct_frame_reader #(
        .FRAME_LEN  (FRAME_LEN),
        .RD_LAT     (2),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut2 (
        .clk_in       (clk_in),
        .rst          (rst),
        .start        (start2),
        .frame_base   (frame_base),
        .intr         (intr2),
        .intr_clr     (intr_clr),
        .busy         (busy2),
        .bram_addrb   (addr2),
        .bram_enb     (enb2),
        .bram_web     (web2),
        .bram_doutb   (dout2),
        .sample_o     (smp2),
        .sample_valid (valid2),
        .sample_ready (sample_ready),
        .sample_last  (last2)
    );

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'h100) >> 2;
        return {16'hDEAD, w[15:0]};
    endfunction

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        dout1  <= enb1 ? bram_word(addr1) : 32'hBAD0_BAD0;
        stage2 <= enb2 ? bram_word(addr2) : 32'hBAD0_BAD0;
        dout2  <= stage2;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ready_mode = 1;   // 0 low, 1 high, 2 pattern 1,0,0,1, 3 random
    logic [3:0]  pat = 4'b1001;

    logic [31:0] exp_addr0[$];
    logic [31:0] exp_addr1[$];
    logic [16:0] exp_smp0[$];
    logic [16:0] exp_smp1[$];
    int unsigned issued[2];
    int unsigned accepted[2];
    bit          stalled[2];
    logic [16:0] held[2];
    bit          done_hs[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input bit d, input logic [31:0] base);
        logic [31:0] a;
        logic [31:0] ai;
        logic [31:0] w;
        a = {base[31:2], 2'b00};
        if (d == 0) begin
            exp_addr0.delete();
            exp_smp0.delete();
        end else begin
            exp_addr1.delete();
            exp_smp1.delete();
        end
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            ai = a + 32'(i) * 32'd4;
            w  = bram_word(ai);
            if (d == 0) begin
                exp_addr0.push_back(ai);
                exp_smp0.push_back({i == int'(FRAME_LEN) - 1, w[15:0]});
            end else begin
                exp_addr1.push_back(ai);
                exp_smp1.push_back({i == int'(FRAME_LEN) - 1, w[15:0]});
            end
        end
        issued[d]   = 0;
        accepted[d] = 0;
        stalled[d]  = 1'b0;
        done_hs[d]  = 1'b0;
    endtask

    task automatic monitor(input bit d, input logic enb, input logic [3:0] web,
                           input logic [31:0] addr, input logic valid,
                           input logic [15:0] smp, input logic last, input logic rdy);
        logic [31:0] ea;
        logic [16:0] es;
        int          sz;
        if (enb) begin
            check_bit($sformatf("credit%0d", d), issued[d] - accepted[d] < FIFO_DEPTH, 1'b1);
            check($sformatf("web%0d", d), 64'(web), 64'd0);
            sz = (d == 0) ? exp_addr0.size() : exp_addr1.size();
            check_bit($sformatf("rd_in_frame%0d", d), sz != 0, 1'b1);
            if (sz != 0) begin
                if (d == 0) ea = exp_addr0.pop_front();
                else        ea = exp_addr1.pop_front();
                check($sformatf("rd_addr%0d", d), 64'(addr), 64'(ea));
            end
            issued[d]++;
        end
        if (valid && stalled[d]) begin
            check($sformatf("stall_hold%0d", d), 64'({last, smp}), 64'(held[d]));
        end
        stalled[d] = valid && !rdy;
        held[d]    = {last, smp};
        if (valid && rdy) begin
            sz = (d == 0) ? exp_smp0.size() : exp_smp1.size();
            check_bit($sformatf("smp_in_frame%0d", d), sz != 0, 1'b1);
            if (sz != 0) begin
                if (d == 0) es = exp_smp0.pop_front();
                else        es = exp_smp1.pop_front();
                check($sformatf("sample%0d_%0d", d, accepted[d]), 64'({last, smp}), 64'(es));
                if (es[16]) done_hs[d] = 1'b1;
            end
            accepted[d]++;
        end
    endtask

    // Outputs are sampled just after the falling edge; ready for the next
    // rising edge is set first so the monitor sees the coming handshake.
    task automatic tick();
        logic       r;
        logic [1:0] pidx;
        @(negedge clk_in);
        pidx = 2'(cyc);
        case (ready_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = pat[pidx];
            default: r = 1'($urandom_range(0, 1));
        endcase
        sample_ready = r;
        #1;
        monitor(1'b0, enb1, web1, addr1, valid1, smp1, last1, r);
        monitor(1'b1, enb2, web2, addr2, valid2, smp2, last2, r);
        cyc++;
    endtask

    task automatic run_until_done(input bit d, input int limit);
        int n;
        n = 0;
        while (!done_hs[d] && n < limit) begin
            tick();
            n++;
        end
        check_bit($sformatf("frame_done%0d", d), done_hs[d], 1'b1);
    endtask

    task automatic run_until_accepted(input bit d, input int unsigned target, input int limit);
        int n;
        n = 0;
        while (accepted[d] < target && n < limit) begin
            tick();
            n++;
        end
        check($sformatf("accepted%0d", d), 64'(accepted[d]), 64'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start1       = 1'b0;
        start2       = 1'b0;
        frame_base   = '0;
        intr_clr     = 1'b0;
        sample_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issued[i]   = 0;
            accepted[i] = 0;
            stalled[i]  = 1'b0;
            done_hs[i]  = 1'b0;
            held[i]     = '0;
        end
        tick();
        tick();
        check("rst_out1", 64'({intr1, busy1, enb1, web1, addr1, valid1, smp1, last1}), 64'd0);
        check("rst_out2", 64'({intr2, busy2, enb2, web2, addr2, valid2, smp2, last2}), 64'd0);
        rst = 1'b0;
        tick();

        // Frame A: base 0x100, ready high, first-valid latency and completion.
        ready_mode = 1;
        load_frame(1'b0, 32'h100);
        frame_base = 32'h100;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_bit("lat1_c1", valid1, 1'b0);
        check_bit("busy_after_start", busy1, 1'b1);
        tick();
        check_bit("lat1_c2", valid1, 1'b0);
        tick();
        check_bit("lat1_c3", valid1, 1'b1);
        run_until_done(1'b0, 600);
        check_bit("intr_before_last_hs", intr1, 1'b0);
        tick();
        check_bit("intr_after_last_hs", intr1, 1'b1);
        check_bit("busy_after_last_hs", busy1, 1'b0);
        check_bit("valid_after_frame", valid1, 1'b0);
        check("count_frame_a", 64'(accepted[0]), 64'(FRAME_LEN));

        // Frame B: 1,0,0,1 backpressure, sticky intr, ignored mid-frame start.
        ready_mode = 2;
        load_frame(1'b0, 32'h2000);
        frame_base = 32'h2000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (40) tick();
        check_bit("intr_sticky", intr1, 1'b1);
        frame_base = 32'h7770;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        intr_clr = 1'b1;
        tick();
        intr_clr = 1'b0;
        check_bit("intr_cleared", intr1, 1'b0);
        check_bit("busy_mid_b", busy1, 1'b1);
        run_until_done(1'b0, 2000);
        intr_clr = 1'b1;
        tick();
        check_bit("intr_set_wins", intr1, 1'b1);
        check_bit("busy_fell_b", busy1, 1'b0);

        // Frame C starts the cycle after busy fell; ready held low for 50 cycles.
        load_frame(1'b0, 32'h3000);
        frame_base = 32'h3000;
        start1     = 1'b1;
        ready_mode = 0;
        tick();
        intr_clr = 1'b0;
        start1   = 1'b0;
        check_bit("intr_clr_next", intr1, 1'b0);
        check_bit("restart_accepted", busy1, 1'b1);
        repeat (50) tick();
        check("hold_reads", 64'(issued[0]), 64'd4);
        check_bit("hold_enb_low", enb1, 1'b0);
        check_bit("hold_valid", valid1, 1'b1);
        ready_mode = 1;
        run_until_done(1'b0, 600);
        tick();
        check_bit("intr_frame_c", intr1, 1'b1);

        // Frame D: reset at sample 100, then restart at base 0 with no stale data.
        load_frame(1'b0, 32'h100);
        frame_base = 32'h100;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_until_accepted(1'b0, 100, 400);
        check_bit("intr_before_rst", intr1, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_out1", 64'({intr1, busy1, enb1, web1, addr1, valid1, smp1, last1}), 64'd0);
        rst = 1'b0;
        load_frame(1'b0, 32'h0);
        frame_base = 32'h0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_until_done(1'b0, 600);
        tick();
        check_bit("intr_frame_d", intr1, 1'b1);

        // Frame E: address wrap, ignored low bits, random ready, mid-frame start.
        intr_clr   = 1'b1;
        ready_mode = 3;
        load_frame(1'b0, 32'hFFFF_FE03);
        frame_base = 32'hFFFF_FE03;
        start1 = 1'b1;
        tick();
        start1   = 1'b0;
        intr_clr = 1'b0;
        check_bit("intr_clr_at_start", intr1, 1'b0);
        repeat (100) tick();
        frame_base = 32'h500;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_until_done(1'b0, 2000);
        tick();
        check_bit("intr_frame_e", intr1, 1'b1);

        // RD_LAT=2 instance: latency, then reset at sample 100 and restart at 0.
        ready_mode = 1;
        load_frame(1'b1, 32'h100);
        frame_base = 32'h100;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check_bit("lat2_c1", valid2, 1'b0);
        tick();
        check_bit("lat2_c2", valid2, 1'b0);
        tick();
        check_bit("lat2_c3", valid2, 1'b0);
        tick();
        check_bit("lat2_c4", valid2, 1'b1);
        run_until_accepted(1'b1, 100, 400);
        rst = 1'b1;
        tick();
        check("midrst_out2", 64'({intr2, busy2, enb2, web2, addr2, valid2, smp2, last2}), 64'd0);
        rst = 1'b0;
        load_frame(1'b1, 32'h0);
        frame_base = 32'h0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        run_until_done(1'b1, 600);
        tick();
        check_bit("intr2_done", intr2, 1'b1);
        check_bit("busy2_done", busy2, 1'b0);
        check("count_frame_lat2", 64'(accepted[1]), 64'(FRAME_LEN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
